// File: rtl/ysyx_220053_ctrl_fsm.sv
// ysyx_220053_ctrl_fsm
//
// Multi-cycle control unit. It sequences each instruction through
// FETCH -> DECODE -> EXEC [-> MEM] -> WB. It latches the fetched instruction
// into an internal IR, registers the decoded control word in DECODE and holds
// it through WB. It also counts retired instructions.
//
// Optional feature macro: YSYX_220053_MDU_EN
//   defined   : OP/OP-32 with funct7=0000001 decode as M-ops. EXEC pulses
//               mdu_start and then waits for mdu_done.
//   undefined : those encodings are illegal, and mdu_start is tied to 0.
//
// Ports
//   clk, rst            core clock, asynchronous active-high reset
//   ifu_req/valid/instr fetch handshake and fetched instruction
//   ALUSrcA, ALUSrcB    ALU operand selects
//   ExtOp, ALUOp        immediate format and ALU function
//   Branch, word_op     branch kind, 32-bit W-op flag
//   mem_op              funct3 of the current load/store
//   lsu_req/we/ack      memory handshake
//   mdu_start/fn/done   multiply/divide handshake
//   reg_wen, pc_we      writeback strobes (WB state only)
//   halt, illegal       sticky trap flags (ebreak / unknown encoding)
//   instret             retired-instruction counter (wraps)

module ysyx_220053_ctrl_fsm #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_req,
    input  logic             ifu_valid,
    input  logic [31:0]      ifu_instr,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ExtOp,
    output logic [3:0]       ALUOp,
    output logic [2:0]       Branch,
    output logic             word_op,
    output logic [2:0]       mem_op,
    output logic             lsu_req,
    output logic             lsu_we,
    input  logic             lsu_ack,
    output logic             mdu_start,
    output logic [2:0]       mdu_fn,
    input  logic             mdu_done,
    output logic             reg_wen,
    output logic             pc_we,
    output logic             halt,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StMem, StWb, StTrap
    } state_e;

    typedef struct packed {
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] ext_op;
        logic [3:0] alu_op;
        logic [2:0] branch;
        logic       word_op;
        logic [2:0] mem_op;
        logic       is_load;
        logic       is_store;
        logic       is_mdu;
        logic [2:0] mdu_fn;
        logic       rd_wen;
    } ctrl_t;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm32  = 7'b0011011;
    localparam logic [6:0] OpReg32  = 7'b0111011;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;
    localparam logic [6:0] F7Mul  = 7'b0000001;

    localparam logic [2:0] ExtI = 3'd0;
    localparam logic [2:0] ExtU = 3'd1;
    localparam logic [2:0] ExtS = 3'd2;
    localparam logic [2:0] ExtB = 3'd3;
    localparam logic [2:0] ExtJ = 3'd4;
    localparam logic [2:0] ExtR = 3'd5;

    localparam logic [1:0] SrcBReg  = 2'd0;
    localparam logic [1:0] SrcBImm  = 2'd1;
    localparam logic [1:0] SrcBFour = 2'd2;

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSlt  = 4'b0010;
    localparam logic [3:0] AluSltu = 4'b0011;
    localparam logic [3:0] AluSub  = 4'b1000;
    localparam logic [3:0] AluMul  = 4'b1001;
    localparam logic [3:0] AluImm  = 4'b1111;

    localparam logic [31:0] InstrEbreak = 32'h0010_0073;

    state_e           state_q, state_d;
    logic [31:0]      ir_q;
    ctrl_t            ctrl_q;
    ctrl_t            dec;
    logic             dec_ill;
    logic             dec_ebreak;
    logic             halt_q;
    logic             illegal_q;
    logic [CNT_W-1:0] instret_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [6:0] sh_f7;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];
    // RV64 immediate shifts carry a 6-bit shamt, so IR[25] is not part of funct7.
    assign sh_f7  = (XLEN == 64) ? {ir_q[31:26], 1'b0} : ir_q[31:25];

    // Register-source fields are consumed by the datapath, not by this unit.
    logic unused_ir;
    assign unused_ir = ^ir_q[24:15];

    // ------------------------------------------------------------------
    // Decoder (combinational from IR, captured into ctrl_q in DECODE)
    // ------------------------------------------------------------------
    always_comb begin
        dec        = '0;
        dec_ill    = 1'b0;
        dec_ebreak = 1'b0;
        if (ir_q == InstrEbreak) begin
            dec_ebreak = 1'b1;
        end else begin
            case (opcode)
                OpLui: begin
                    dec.alu_src_b = SrcBImm;
                    dec.ext_op    = ExtU;
                    dec.alu_op    = AluImm;
                    dec.rd_wen    = 1'b1;
                end
                OpAuipc: begin
                    dec.alu_src_b = SrcBImm;
                    dec.ext_op    = ExtU;
                    dec.alu_op    = AluAdd;
                    dec.rd_wen    = 1'b1;
                end
                OpJal: begin
                    dec.alu_src_b = SrcBFour;
                    dec.ext_op    = ExtJ;
                    dec.branch    = 3'b001;
                    dec.rd_wen    = 1'b1;
                end
                OpJalr: begin
                    dec.alu_src_b = SrcBFour;
                    dec.ext_op    = ExtI;
                    dec.branch    = 3'b010;
                    dec.rd_wen    = 1'b1;
                    dec_ill       = (funct3 != 3'b000);
                end
                OpBranch: begin
                    dec.alu_src_a = 1'b1;
                    dec.alu_src_b = SrcBReg;
                    dec.ext_op    = ExtB;
                    // beq/bne compare by subtraction; blt[u]/bge[u] by set-less-than.
                    dec.branch    = {1'b1, funct3[2], funct3[0]};
                    case (funct3[2:1])
                        2'b00:   dec.alu_op = AluSub;
                        2'b10:   dec.alu_op = AluSlt;
                        2'b11:   dec.alu_op = AluSltu;
                        default: dec_ill    = 1'b1;
                    endcase
                end
                OpLoad: begin
                    dec.alu_src_a = 1'b1;
                    dec.alu_src_b = SrcBImm;
                    dec.ext_op    = ExtI;
                    dec.alu_op    = AluAdd;
                    dec.mem_op    = funct3;
                    dec.is_load   = 1'b1;
                    dec.rd_wen    = 1'b1;
                    case (funct3)
                        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec_ill = 1'b0;
                        3'b011, 3'b110:                         dec_ill = (XLEN != 64);
                        default:                                dec_ill = 1'b1;
                    endcase
                end
                OpStore: begin
                    dec.alu_src_a = 1'b1;
                    dec.alu_src_b = SrcBImm;
                    dec.ext_op    = ExtS;
                    dec.alu_op    = AluAdd;
                    dec.mem_op    = funct3;
                    dec.is_store  = 1'b1;
                    case (funct3)
                        3'b000, 3'b001, 3'b010: dec_ill = 1'b0;
                        3'b011:                 dec_ill = (XLEN != 64);
                        default:                dec_ill = 1'b1;
                    endcase
                end
                OpImm, OpImm32: begin
                    dec.alu_src_a = 1'b1;
                    dec.alu_src_b = SrcBImm;
                    dec.ext_op    = ExtI;
                    dec.alu_op    = {1'b0, funct3};
                    dec.word_op   = (opcode == OpImm32);
                    dec.rd_wen    = 1'b1;
                    if (opcode == OpImm32) begin
                        // W shifts always use a 5-bit shamt.
                        case (funct3)
                            3'b000:  dec_ill = 1'b0;
                            3'b001:  dec_ill = (funct7 != F7Base);
                            3'b101:  dec_ill = (funct7 != F7Base) && (funct7 != F7Alt);
                            default: dec_ill = 1'b1;
                        endcase
                        if (XLEN != 64) dec_ill = 1'b1;
                    end else if (funct3 == 3'b001) begin
                        dec_ill = (sh_f7 != F7Base);
                    end else if (funct3 == 3'b101) begin
                        dec_ill = (sh_f7 != F7Base) && (sh_f7 != F7Alt);
                    end
                    if (funct3 == 3'b101) dec.alu_op = {ir_q[30], funct3};
                end
                OpReg, OpReg32: begin
                    dec.alu_src_a = 1'b1;
                    dec.alu_src_b = SrcBReg;
                    dec.ext_op    = ExtR;
                    dec.word_op   = (opcode == OpReg32);
                    dec.rd_wen    = 1'b1;
                    if (funct7 == F7Base) begin
                        dec.alu_op = {1'b0, funct3};
                        if (opcode == OpReg32) begin
                            dec_ill = (funct3 != 3'b000) && (funct3 != 3'b001) &&
                                      (funct3 != 3'b101);
                        end
                    end else if (funct7 == F7Alt &&
                                 (funct3 == 3'b000 || funct3 == 3'b101)) begin
                        dec.alu_op = {1'b1, funct3};
                    end else if (funct7 == F7Mul) begin
`ifdef YSYX_220053_MDU_EN
                        dec.is_mdu = 1'b1;
                        dec.alu_op = AluMul;
                        dec.mdu_fn = funct3;
                        // No 32-bit forms of mulh/mulhsu/mulhu.
                        if (opcode == OpReg32) begin
                            dec_ill = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                                      (funct3 == 3'b011);
                        end
`else
                        dec_ill = 1'b1;
`endif
                    end else begin
                        dec_ill = 1'b1;
                    end
                    if (opcode == OpReg32 && XLEN != 64) dec_ill = 1'b1;
                end
                default: dec_ill = 1'b1;
            endcase
            if (ir_q[11:7] == 5'd0) dec.rd_wen = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  if (ifu_valid) state_d = StDecode;
            StDecode: state_d = (dec_ebreak || dec_ill) ? StTrap : StExec;
            StExec: begin
                if (ctrl_q.is_mdu) begin
                    if (mdu_done) state_d = StWb;
                end else if (ctrl_q.is_load || ctrl_q.is_store) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem:    if (lsu_ack) state_d = StWb;
            StWb:     state_d = StFetch;
            StTrap:   state_d = StTrap;
            default:  state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // State, IR, control word, flags and counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            ctrl_q    <= '0;
            halt_q    <= 1'b0;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StFetch && ifu_valid) ir_q <= ifu_instr;
            if (state_q == StDecode) begin
                // A trapping instruction leaves a cleared control word behind.
                ctrl_q <= (dec_ebreak || dec_ill) ? '0 : dec;
                if (dec_ebreak) halt_q <= 1'b1;
                if (dec_ill)    illegal_q <= 1'b1;
            end
            if (state_q == StWb) instret_q <= instret_q + CNT_W'(1);
        end
    end

`ifdef YSYX_220053_MDU_EN
    // Set after the first EXEC cycle of an instruction so the start is a single pulse.
    logic mdu_busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdu_busy_q <= 1'b0;
        end else begin
            mdu_busy_q <= (state_q == StExec) && (state_d == StExec);
        end
    end

    assign mdu_start = (state_q == StExec) && ctrl_q.is_mdu && !mdu_busy_q;
`else
    assign mdu_start = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs (strobes decode from state only, so reset clears them at once)
    // ------------------------------------------------------------------
    always_comb begin
        ifu_req = (state_q == StFetch);
        lsu_req = (state_q == StMem);
        lsu_we  = (state_q == StMem) && ctrl_q.is_store;
        pc_we   = (state_q == StWb);
        reg_wen = (state_q == StWb) && ctrl_q.rd_wen;
    end

    assign ALUSrcA = ctrl_q.alu_src_a;
    assign ALUSrcB = ctrl_q.alu_src_b;
    assign ExtOp   = ctrl_q.ext_op;
    assign ALUOp   = ctrl_q.alu_op;
    assign Branch  = ctrl_q.branch;
    assign word_op = ctrl_q.word_op;
    assign mem_op  = ctrl_q.mem_op;
    assign mdu_fn  = ctrl_q.mdu_fn;
    assign halt    = halt_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: doc/ysyx_220053_ctrl_fsm.md
# ysyx_220053_ctrl_fsm

Multi-cycle control unit for the next-generation NPC core. It replaces the single-cycle combinational decoder with a state machine that sequences fetch, decode, execute, memory and writeback. It performs handshakes with the IFU, LSU and an optional multiply/divide unit (MDU), and registers the decoded control word for the whole instruction. It sits between the IFU and the datapath (ALU, immediate extender, register file, PC logic) and also counts retired instructions.

## Interface
Parameters:
- XLEN, 64, datapath width; 32 or 64. W-type opcodes (0011011, 0111011) are legal only when XLEN=64.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- ifu_req  out  1  fetch request
- ifu_valid  in  1  instruction valid; a transfer occurs when ifu_req && ifu_valid
- ifu_instr  in  32  fetched instruction
- ALUSrcA  out  1  0: pc, 1: busA
- ALUSrcB  out  2  0: busB, 1: imm, 2: const 4
- ExtOp  out  3  I=0, U=1, S=2, B=3, J=4, R=5
- ALUOp  out  4  add 0000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, or 0110, and 0111, sub 1000, mul-class 1001, sra 1101, pass-imm 1111
- Branch  out  3  none 000, jal 001, jalr 010, beq 100, bne 101, blt 110, bge 111
- word_op  out  1  32-bit W-type operation
- mem_op  out  3  funct3 of the current load/store
- lsu_req, lsu_we  out  1 each  memory request / store
- lsu_ack  in  1  memory done
- mdu_start  out  1  one-cycle start pulse
- mdu_fn  out  3  funct3 of the M-op
- mdu_done  in  1  MDU result ready
- reg_wen  out  1  register-file write strobe
- pc_we  out  1  PC update strobe
- halt  out  1  sticky, set by ebreak
- illegal  out  1  sticky, set by an unknown encoding
- instret  out  CNT_W  count of retired instructions

## Operation
States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE: one cycle after reset deasserts, then FETCH.
- FETCH: ifu_req=1 until ifu_valid. The instruction is latched into an internal IR, then the FSM goes to DECODE.
- DECODE: one cycle. Decodes IR into the control word and registers it. The control word is held constant through WB.
  - ebreak (IR==32'h00100073): set halt, go to TRAP.
  - Unknown opcode/funct3/funct7: set illegal, go to TRAP.
  - Otherwise go to EXEC.
- EXEC:
  - MDU op: mdu_start is pulsed in the first EXEC cycle only. The FSM waits for mdu_done, then goes to WB.
  - Load/store: go to MEM after one cycle.
  - All others: go to WB after one cycle.
- MEM: lsu_req=1 (lsu_we=1 for stores) until lsu_ack, then WB.
- WB: one cycle.
  - pc_we=1.
  - reg_wen=1 for every instruction except stores and branches, and except when rd=0.
  - instret increments.
  - Next state FETCH.
- TRAP: all strobes are 0. The FSM stays in TRAP until reset.

Decode rules:
- lui, auipc, jal, jalr, OP-IMM, OP and branches use the same field encodings as the current decoder. Within OP-IMM/OP, funct3=101 selects srl vs sra by IR[30].
- Loads: ALUSrcA=1, ALUSrcB=1, ExtOp=I, ALUOp=add.
- Stores: as loads but ExtOp=S.
- W-ops: word_op=1; otherwise decoded as the 64-bit op.
- Branches: bltu/bgeu use ALUOp=sltu with Branch 110/111; the signed branches use slt.

## Timing
- Reset values: state IDLE, IR=0, all control outputs 0, all strobes 0, halt=0, illegal=0, instret=0.
- Minimum latency per instruction (ifu_valid in the FETCH entry cycle): ALU op 4 cycles (FETCH, DECODE, EXEC, WB); load/store 5 cycles with lsu_ack in the first MEM cycle.
- Each wait cycle on ifu_valid, lsu_ack or mdu_done adds one cycle.
- If mdu_done arrives in the same cycle as mdu_start, it is accepted and the next state is WB.
- lsu_req and ifu_req stay high until acknowledged; they never drop mid-wait.
- instret wraps modulo 2^CNT_W.
- Reset mid-operation (any state): outputs return to reset values asynchronously. No WB strobe is emitted for the aborted instruction.
- Handshake inputs are ignored outside their own state.

## Configuration
- YSYX_220053_MDU_EN defined:
  - OP/OP-32 with funct7=0000001 are decoded as M-ops: ALUOp=1001, mdu_fn=funct3.
  - EXEC waits on mdu_done.
- Not defined:
  - Those encodings raise illegal and go to TRAP.
  - mdu_start is tied to 0.

## Test plan
- addi x1,x0,5 (0x00500093), ifu_valid at once -> DECODE gives ALUSrcA=1, ALUSrcB=1, ALUOp=0000, ExtOp=0; reg_wen and pc_we pulse in cycle 4; instret=1.
- lw, lsu_ack 3 cycles after MEM entry -> lsu_req high for exactly 4 cycles, lsu_we=0, mem_op=010; WB in cycle 8.
- mul (0x02208033) with MDU_EN, mdu_done 5 cycles after start -> mdu_start high exactly 1 cycle, ALUOp=1001, single WB. Without MDU_EN -> illegal=1, state TRAP, no reg_wen.
- bgeu (funct3 111) -> ALUOp=0011, Branch=111, reg_wen=0, pc_we=1.
- ebreak (0x00100073) -> halt=1 from the cycle after DECODE; a later ifu_valid causes no ifu_req and no strobes.
- rst asserted during MEM while lsu_req=1 -> lsu_req=0 immediately; after release: 1 IDLE cycle, then ifu_req=1; instret unchanged at 0.
